// File: rtl/bcrypt_core_seq.sv
// Job sequencer in front of the bcrypt key-setup loop core: drives the start command
// bus and watches the done status. Define BCRYPT_SEQ_CYCLE_CNT_EN to build the COMPUTE cycle counter.
module bcrypt_core_seq #(
  parameter int          MIN_IDLE = 4,
  parameter logic [31:0] TIMEOUT  = 32'd0,
  parameter int          DW       = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          go,
  input  logic          abort,
  output logic [DW-1:0] core_start,
  input  logic [DW-1:0] core_done,
  output logic          busy,
  output logic          finished,
  output logic          err,
  output logic [1:0]    err_code,
  output logic [31:0]   cycle_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_LOAD, S_COMPUTE, S_STORE, S_FINISH, S_ERROR
  } state_t;

  localparam logic [31:0] PRE_LAST = (MIN_IDLE > 1) ? 32'(MIN_IDLE - 1) : 32'd0;
  localparam logic [31:0] TO_LAST  = TIMEOUT - 32'd1;
  localparam logic [1:0]  EC_NONE  = 2'b00;
  localparam logic [1:0]  EC_PROTO = 2'b01;
  localparam logic [1:0]  EC_TIME  = 2'b10;

  localparam logic [DW-1:0] DONE_0  = '0;
  localparam logic [DW-1:0] DONE_1  = DW'(1);
  localparam logic [DW-1:0] DONE_2  = DW'(2);
  localparam logic [DW-1:0] DONE_FF = DW'(8'hFF);

  state_t      state, nxt;
  logic [31:0] timer;
  logic [1:0]  nxt_code;
  logic        timing;
  logic        to_hit;
  logic [1:0]  cmd;

  assign timing = (state == S_PRE) || (state == S_LOAD) ||
                  (state == S_COMPUTE) || (state == S_STORE);
  // Fires on the last permitted cycle so ERROR is entered exactly TIMEOUT cycles after phase entry.
  assign to_hit = (TIMEOUT != 32'd0) && (timer >= TO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      err_code <= EC_NONE;
    end else begin
      state    <= nxt;
      err_code <= nxt_code;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             timer <= '0;
    else if (nxt != state)                  timer <= '0;
    else if (timing && (timer != '1))       timer <= timer + 32'd1;
  end

  always_comb begin
    nxt      = state;
    nxt_code = err_code;
    case (state)
      S_IDLE: if (go) begin
        nxt      = S_PRE;
        nxt_code = EC_NONE;
      end
      S_PRE: if (timer >= PRE_LAST) nxt = S_LOAD;
      S_LOAD: begin
        if (core_done == DONE_1)      nxt = S_COMPUTE;
        else if (core_done != DONE_0) begin nxt = S_ERROR; nxt_code = EC_PROTO; end
        else if (to_hit)              begin nxt = S_ERROR; nxt_code = EC_TIME;  end
      end
      // done==1 is the previous phase's status still in flight, not an error.
      S_COMPUTE: begin
        if (core_done == DONE_2)      nxt = S_STORE;
        else if (core_done != DONE_1) begin nxt = S_ERROR; nxt_code = EC_PROTO; end
        else if (to_hit)              begin nxt = S_ERROR; nxt_code = EC_TIME;  end
      end
      S_STORE: begin
        if (core_done == DONE_FF)     nxt = S_FINISH;
        else if (core_done != DONE_2) begin nxt = S_ERROR; nxt_code = EC_PROTO; end
        else if (to_hit)              begin nxt = S_ERROR; nxt_code = EC_TIME;  end
      end
      S_FINISH: if (go) nxt = S_PRE;
      S_ERROR: if (go) begin
        nxt      = S_PRE;
        nxt_code = EC_NONE;
      end
      default: nxt = S_IDLE;
    endcase
    if (abort) begin
      nxt      = S_IDLE;
      nxt_code = err_code;
    end
  end

  // Decoded straight from the state register so an async reset drops start immediately.
  always_comb begin
    cmd = 2'd0;
    case (state)
      S_LOAD:             cmd = 2'd1;
      S_COMPUTE:          cmd = 2'd2;
      S_STORE, S_FINISH:  cmd = 2'd3;
      default:            cmd = 2'd0;
    endcase
  end

  assign core_start = {{(DW-2){1'b0}}, cmd};
  assign busy       = timing;
  assign finished   = (state == S_FINISH);
  assign err        = (state == S_ERROR);

`ifdef BCRYPT_SEQ_CYCLE_CNT_EN
  logic [31:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                      cnt <= '0;
    else if ((nxt == S_PRE) && (state != S_PRE))     cnt <= '0;
    else if ((state == S_COMPUTE) && (cnt != '1))    cnt <= cnt + 32'd1;
  end

  assign cycle_count = cnt;
`else
  assign cycle_count = 32'd0;
`endif

endmodule

// File: tb/tb_bcrypt_core_seq.sv
// Directed bench for bcrypt_core_seq: a per-cycle vector table plus hand sequences
// for the long job, abort, async reset and timeout cases.
module tb_bcrypt_core_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        go = 1'b0, abort = 1'b0;
  logic [31:0] core_done = '0;
  logic [31:0] core_start;
  logic        busy, finished, err;
  logic [1:0]  err_code;
  logic [31:0] cycle_count;

  logic        go2 = 1'b0, abort2 = 1'b0;
  logic [31:0] done2 = '0;
  logic [31:0] start2;
  logic        busy2, fin2, err2;
  logic [1:0]  code2;
  logic [31:0] cc2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  bcrypt_core_seq #(.MIN_IDLE(4), .TIMEOUT(32'd0), .DW(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .go(go), .abort(abort),
    .core_start(core_start), .core_done(core_done),
    .busy(busy), .finished(finished), .err(err), .err_code(err_code),
    .cycle_count(cycle_count)
  );

  bcrypt_core_seq #(.MIN_IDLE(4), .TIMEOUT(32'd200), .DW(32)) u_to (
    .clk(clk), .rst_n(rst_n), .go(go2), .abort(abort2),
    .core_start(start2), .core_done(done2),
    .busy(busy2), .finished(fin2), .err(err2), .err_code(code2),
    .cycle_count(cc2)
  );

  typedef struct {
    logic        go;
    logic        abort;
    logic [31:0] done;
    logic [31:0] start;
    logic        busy;
    logic        fin;
    logic        err;
    logic [1:0]  code;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string name, input logic [31:0] s, input logic b,
                         input logic f, input logic e, input logic [1:0] c);
    chk({name, ".start"}, core_start, s);
    chk({name, ".busy"}, {31'd0, busy}, {31'd0, b});
    chk({name, ".finished"}, {31'd0, finished}, {31'd0, f});
    chk({name, ".err"}, {31'd0, err}, {31'd0, e});
    chk({name, ".err_code"}, {30'd0, err_code}, {30'd0, c});
  endtask

  vec_t vt[24];
  int   n;
  logic ok;

  initial begin
    // go, abort, done, start, busy, fin, err, code
    vt[0]  = '{1'b1, 1'b0, 32'h0,  32'd0, 1'b1, 1'b0, 1'b0, 2'b00};
    vt[1]  = '{1'b0, 1'b0, 32'h0,  32'd0, 1'b1, 1'b0, 1'b0, 2'b00};
    vt[2]  = '{1'b0, 1'b0, 32'h0,  32'd0, 1'b1, 1'b0, 1'b0, 2'b00};
    vt[3]  = '{1'b0, 1'b0, 32'h0,  32'd0, 1'b1, 1'b0, 1'b0, 2'b00};
    vt[4]  = '{1'b0, 1'b0, 32'h0,  32'd1, 1'b1, 1'b0, 1'b0, 2'b00};
    vt[5]  = '{1'b0, 1'b0, 32'h0,  32'd1, 1'b1, 1'b0, 1'b0, 2'b00};
    vt[6]  = '{1'b0, 1'b0, 32'h1,  32'd2, 1'b1, 1'b0, 1'b0, 2'b00};
    vt[7]  = '{1'b0, 1'b0, 32'h1,  32'd2, 1'b1, 1'b0, 1'b0, 2'b00};
    vt[8]  = '{1'b0, 1'b0, 32'h2,  32'd3, 1'b1, 1'b0, 1'b0, 2'b00};
    vt[9]  = '{1'b0, 1'b0, 32'h2,  32'd3, 1'b1, 1'b0, 1'b0, 2'b00};
    vt[10] = '{1'b0, 1'b0, 32'hFF, 32'd3, 1'b0, 1'b1, 1'b0, 2'b00};
    vt[11] = '{1'b0, 1'b0, 32'hFF, 32'd3, 1'b0, 1'b1, 1'b0, 2'b00};
    vt[12] = '{1'b1, 1'b0, 32'h0,  32'd0, 1'b1, 1'b0, 1'b0, 2'b00};
    vt[13] = '{1'b0, 1'b0, 32'h0,  32'd0, 1'b1, 1'b0, 1'b0, 2'b00};
    vt[14] = '{1'b0, 1'b0, 32'h0,  32'd0, 1'b1, 1'b0, 1'b0, 2'b00};
    vt[15] = '{1'b0, 1'b0, 32'h0,  32'd0, 1'b1, 1'b0, 1'b0, 2'b00};
    vt[16] = '{1'b0, 1'b0, 32'h0,  32'd1, 1'b1, 1'b0, 1'b0, 2'b00};
    vt[17] = '{1'b0, 1'b0, 32'h1,  32'd2, 1'b1, 1'b0, 1'b0, 2'b00};
    vt[18] = '{1'b0, 1'b0, 32'h7,  32'd0, 1'b0, 1'b0, 1'b1, 2'b01};
    vt[19] = '{1'b0, 1'b0, 32'h0,  32'd0, 1'b0, 1'b0, 1'b1, 2'b01};
    vt[20] = '{1'b0, 1'b1, 32'h0,  32'd0, 1'b0, 1'b0, 1'b0, 2'b01};
    vt[21] = '{1'b1, 1'b1, 32'h0,  32'd0, 1'b0, 1'b0, 1'b0, 2'b01};
    vt[22] = '{1'b1, 1'b0, 32'h0,  32'd0, 1'b1, 1'b0, 1'b0, 2'b00};
    vt[23] = '{1'b0, 1'b1, 32'h0,  32'd0, 1'b0, 1'b0, 1'b0, 2'b00};

    #12;
    chk_all("reset", 32'd0, 1'b0, 1'b0, 1'b0, 2'b00);
    chk("reset.cycle_count", cycle_count, 32'd0);
    chk("reset.to_start", start2, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 24; i++) begin
      go = vt[i].go; abort = vt[i].abort; core_done = vt[i].done;
      step();
      chk_all($sformatf("vec%0d", i), vt[i].start, vt[i].busy, vt[i].fin, vt[i].err, vt[i].code);
    end
    go = 1'b0; abort = 1'b0; core_done = '0;
    step();

    // Long job with a model core; go pulsed mid-COMPUTE must be ignored.
    go = 1'b1; step(); go = 1'b0;
    n = 0;
    while (core_start == 32'd0 && n < 20) begin n++; step(); end
    chk("job.pre_cycles", n, 32'd4);
    chk("job.load_start", core_start, 32'd1);
    ok = 1'b1;
    repeat (99) begin step(); if (core_start != 32'd1) ok = 1'b0; end
    chk("job.load_hold", {31'd0, ok}, 32'd1);
    core_done = 32'd1; step();
    chk("job.compute_start", core_start, 32'd2);
    ok = 1'b1;
    for (int k = 0; k < 499; k++) begin
      go = (k == 200);
      step();
      if (core_start != 32'd2 || !busy) ok = 1'b0;
    end
    go = 1'b0;
    chk("job.compute_hold_go_ignored", {31'd0, ok}, 32'd1);
    core_done = 32'd2; step();
    chk("job.store_start", core_start, 32'd3);
    repeat (49) step();
    core_done = 32'hFF; step();
    chk_all("job.finish", 32'd3, 1'b0, 1'b1, 1'b0, 2'b00);
`ifdef BCRYPT_SEQ_CYCLE_CNT_EN
    chk("job.cycle_count_range", {31'd0, (cycle_count >= 32'd499 && cycle_count <= 32'd501)}, 32'd1);
`else
    chk("job.cycle_count_tied", cycle_count, 32'd0);
`endif

    // Restart from FINISH, then abort together with go in STORE.
    core_done = 32'd0; go = 1'b1; step(); go = 1'b0;
    n = 0;
    while (core_start == 32'd0 && n < 20) begin n++; step(); end
    chk("restart.pre_cycles", n, 32'd4);
    chk("restart.finished_clear", {31'd0, finished}, 32'd0);
    core_done = 32'd1; step();
    core_done = 32'd2; step();
    chk("restart.store", core_start, 32'd3);
    abort = 1'b1; go = 1'b1; step();
    abort = 1'b0; go = 1'b0;
    chk_all("abort_store", 32'd0, 1'b0, 1'b0, 1'b0, 2'b00);
    step();
    chk("abort_store.stays_idle", {31'd0, busy}, 32'd0);

    // Async reset mid-COMPUTE.
    core_done = 32'd0; go = 1'b1; step(); go = 1'b0;
    repeat (4) step();
    core_done = 32'd1; step();
    chk("arst.in_compute", core_start, 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.start_now", core_start, 32'd0);
    chk("arst.busy_now", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    core_done = 32'd2;
    step(); step();
    chk_all("arst.idle", 32'd0, 1'b0, 1'b0, 1'b0, 2'b00);
    core_done = 32'd0; go = 1'b1; step(); go = 1'b0;
    chk("arst.go_restarts", {31'd0, busy}, 32'd1);
    abort = 1'b1; step(); abort = 1'b0;

    // Timeout in LOAD on the TIMEOUT=200 instance.
    done2 = 32'd0; go2 = 1'b1; step(); go2 = 1'b0;
    n = 0;
    while (start2 != 32'd1 && n < 20) begin n++; step(); end
    chk("to.load_entry", start2, 32'd1);
    n = 0;
    while (!err2 && n < 400) begin step(); n++; end
    chk("to.cycles", n, 32'd200);
    chk("to.err_code", {30'd0, code2}, 32'd2);
    chk("to.start", start2, 32'd0);
    chk("to.busy", {31'd0, busy2}, 32'd0);
    go2 = 1'b1; step(); go2 = 1'b0;
    chk("to.go_clears", {31'd0, err2, code2}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
